// File: rtl/branch_metric_pingpong.sv
// Branch-metric generator feeding a two-bank ping-pong store: the writer fills one
// bank while the alpha/beta recursions read the other.

module bm_lane #(
  parameter int DWIDTH = 16,
  parameter int MWIDTH = 16,
  parameter int SHIFT  = 1
) (
  input  logic signed [DWIDTH-1:0] sys,
  input  logic signed [DWIDTH-1:0] apr,
  input  logic signed [DWIDTH-1:0] par,
  input  logic                     neg,
  output logic signed [MWIDTH-1:0] m
);
  localparam int XW   = DWIDTH + 2;
  localparam int MAXI = (1 << (MWIDTH-1)) - 1;
  localparam logic signed [XW-1:0] MAXV = XW'(MAXI);
  localparam logic signed [XW-1:0] MINV = XW'(-MAXI);

  logic signed [XW-1:0] s, t, sh;

  // symmetric clamp: the most-negative code would break metric negation
  always_comb begin
    s  = XW'(sys) + XW'(apr);
    t  = neg ? (s - XW'(par)) : (s + XW'(par));
    sh = t >>> SHIFT;
    if (sh > MAXV)      m = MAXV[MWIDTH-1:0];
    else if (sh < MINV) m = MINV[MWIDTH-1:0];
    else                m = sh[MWIDTH-1:0];
  end
endmodule

module branch_metric_pingpong #(
  parameter int DWIDTH      = 16,
  parameter int MWIDTH      = 16,
  parameter int BRANCH_SIZE = 3072,
  parameter int SHIFT       = 1,
  parameter int AW          = $clog2(BRANCH_SIZE)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic signed [DWIDTH-1:0] i_sys,
  input  logic signed [DWIDTH-1:0] i_par,
  input  logic signed [DWIDTH-1:0] i_apr,
  input  logic [AW-1:0]            i_addr,
  input  logic                     i_valid,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic                     o_frame_ready,
  output logic                     o_rd_bank,
  output logic [AW:0]              o_frame_len,
  input  logic [AW-1:0]            i_rd_addr,
  input  logic                     i_rd_done,
  output logic signed [MWIDTH-1:0] o_metric0,
  output logic signed [MWIDTH-1:0] o_metric1,
  output logic                     o_err_addr
);
  localparam logic [AW:0] BSZ = (AW+1)'(BRANCH_SIZE);

  typedef struct packed {
    logic signed [MWIDTH-1:0] m1;
    logic signed [MWIDTH-1:0] m0;
  } bm_t;

  logic [1:0][MWIDTH-1:0] m_c;
  logic [1:0]             full, fresh;
  logic                   wb, rb, err;
  logic [1:0][AW:0]       len;
  logic                   acc, comp, rel, oor;

  logic          s1_vld, s1_bank;
  logic [AW-1:0] s1_addr;
  bm_t           s1_bm, rd_q;
  bm_t           mem [2][BRANCH_SIZE];

  // lane 0: (u=+1,p=+1), lane 1: (u=+1,p=-1)
  for (genvar g = 0; g < 2; g++) begin : g_lane
    bm_lane #(.DWIDTH(DWIDTH), .MWIDTH(MWIDTH), .SHIFT(SHIFT)) u_lane (
      .sys(i_sys), .apr(i_apr), .par(i_par), .neg(1'(g)), .m(m_c[g])
    );
  end

  assign o_ready = !full[wb];
  assign acc     = i_valid && o_ready;
  assign comp    = acc && i_last;
  assign rel     = i_rd_done && full[rb];
  assign oor     = {1'b0, i_addr} >= BSZ;

  // rel and comp always hit different banks, since a FULL bank is never written
  always_ff @(posedge aclk) begin
    if (areset) begin
      full   <= '0;
      fresh  <= '1;
      wb     <= 1'b0;
      rb     <= 1'b0;
      len    <= '0;
      err    <= 1'b0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= acc && !oor;
      if (acc) begin
        len[wb]   <= fresh[wb] ? (AW+1)'(1) : len[wb] + 1'b1;
        fresh[wb] <= i_last;
        err       <= err | oor;
      end
      if (rel) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
      if (comp) begin
        full[wb] <= 1'b1;
        wb       <= ~wb;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (acc) begin
      s1_bm   <= '{m1: m_c[1], m0: m_c[0]};
      s1_addr <= i_addr;
      s1_bank <= wb;
    end
  end

  always_ff @(posedge aclk) begin
    if (s1_vld) mem[s1_bank][s1_addr] <= s1_bm;
  end

  always_ff @(posedge aclk) begin
    if (areset) rd_q <= '0;
    else        rd_q <= mem[rb][i_rd_addr];
  end

  assign o_frame_ready = full[rb];
  assign o_rd_bank     = rb;
  assign o_frame_len   = len[rb];
  assign o_metric0     = rd_q.m0;
  assign o_metric1     = rd_q.m1;
  assign o_err_addr    = err;
endmodule

// File: tb/tb_branch_metric_pingpong.sv
// Random-stimulus bench for branch_metric_pingpong; a 16-bit/shift-1 and an 8-bit/shift-0
// instance share all inputs and are checked against an integer reference model.

module tb_branch_metric_pingpong;
  localparam int BS = 3072;
  localparam int AW = 12;

  logic aclk = 1'b0;
  logic areset;
  logic signed [15:0] i_sys, i_par, i_apr;
  logic [AW-1:0] i_addr, i_rd_addr;
  logic i_valid, i_last, i_rd_done;

  logic o_ready, o_frame_ready, o_rd_bank, o_err_addr;
  logic [AW:0] o_frame_len;
  logic signed [15:0] o_metric0, o_metric1;

  logic s_ready, s_frame_ready, s_rd_bank, s_err_addr;
  logic [AW:0] s_frame_len;
  logic signed [7:0] s_metric0, s_metric1;

  always #5 aclk = ~aclk;

  branch_metric_pingpong #(.DWIDTH(16), .MWIDTH(16), .BRANCH_SIZE(BS), .SHIFT(1)) u_dut (
    .aclk(aclk), .areset(areset), .i_sys(i_sys), .i_par(i_par), .i_apr(i_apr),
    .i_addr(i_addr), .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready),
    .o_frame_ready(o_frame_ready), .o_rd_bank(o_rd_bank), .o_frame_len(o_frame_len),
    .i_rd_addr(i_rd_addr), .i_rd_done(i_rd_done), .o_metric0(o_metric0),
    .o_metric1(o_metric1), .o_err_addr(o_err_addr)
  );

  branch_metric_pingpong #(.DWIDTH(16), .MWIDTH(8), .BRANCH_SIZE(BS), .SHIFT(0)) u_dut_sat (
    .aclk(aclk), .areset(areset), .i_sys(i_sys), .i_par(i_par), .i_apr(i_apr),
    .i_addr(i_addr), .i_valid(i_valid), .i_last(i_last), .o_ready(s_ready),
    .o_frame_ready(s_frame_ready), .o_rd_bank(s_rd_bank), .o_frame_len(s_frame_len),
    .i_rd_addr(i_rd_addr), .i_rd_done(i_rd_done), .o_metric0(s_metric0),
    .o_metric1(s_metric1), .o_err_addr(s_err_addr)
  );

  // reference state: stored inputs per bank/address plus bank bookkeeping
  int ref_s [2][BS];
  int ref_a [2][BS];
  int ref_p [2][BS];
  bit mfull [2];
  bit mfresh[2];
  int mlen  [2];
  bit mwb, mrb, merr;
  int n_chk, n_bad;

  function automatic int exp_m(int s, int a, int p, bit neg, int mw, int sh);
    int t, mx;
    t  = neg ? (s + a - p) : (s + a + p);
    t  = t >>> sh;
    mx = (1 << (mw - 1)) - 1;
    if (t > mx)  t = mx;
    if (t < -mx) t = -mx;
    return t;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      mfull[b] = 0; mfresh[b] = 1; mlen[b] = 0;
    end
    mwb = 0; mrb = 0; merr = 0;
  endtask

  task automatic model_accept(input int s, input int a, input int p, input int addr, input bit last);
    if (addr < BS) begin
      ref_s[mwb][addr] = s; ref_a[mwb][addr] = a; ref_p[mwb][addr] = p;
    end else merr = 1;
    mlen[mwb]   = mfresh[mwb] ? 1 : mlen[mwb] + 1;
    mfresh[mwb] = last;
    if (last) begin
      mfull[mwb] = 1;
      mwb = !mwb;
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ":ready"},   o_ready,       !mfull[mwb]);
    chk({tag, ":frdy"},    o_frame_ready, mfull[mrb]);
    chk({tag, ":rbank"},   o_rd_bank,     mrb);
    chk({tag, ":len"},     o_frame_len,   mlen[mrb]);
    chk({tag, ":err"},     o_err_addr,    merr);
    chk({tag, ":s_ready"}, s_ready,       !mfull[mwb]);
    chk({tag, ":s_frdy"},  s_frame_ready, mfull[mrb]);
    chk({tag, ":s_rbank"}, s_rd_bank,     mrb);
    chk({tag, ":s_len"},   s_frame_len,   mlen[mrb]);
    chk({tag, ":s_err"},   s_err_addr,    merr);
  endtask

  task automatic send_beat(input int s, input int a, input int p, input int addr, input bit last);
    bit rdy;
    i_sys = 16'(s); i_apr = 16'(a); i_par = 16'(p);
    i_addr = AW'(addr); i_last = last; i_valid = 1'b1;
    for (int c = 0; ; c++) begin
      if (c >= 64) begin
        chk("beat_timeout", o_ready, 1);
        break;
      end
      rdy = o_ready;
      step();
      if (rdy) begin
        model_accept(s, a, p, addr, last);
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int addr);
    int b;
    i_rd_addr = AW'(addr);
    step();
    b = mrb;
    chk({tag, ":m0"},   o_metric0, exp_m(ref_s[b][addr], ref_a[b][addr], ref_p[b][addr], 0, 16, 1));
    chk({tag, ":m1"},   o_metric1, exp_m(ref_s[b][addr], ref_a[b][addr], ref_p[b][addr], 1, 16, 1));
    chk({tag, ":s_m0"}, s_metric0, exp_m(ref_s[b][addr], ref_a[b][addr], ref_p[b][addr], 0, 8, 0));
    chk({tag, ":s_m1"}, s_metric1, exp_m(ref_s[b][addr], ref_a[b][addr], ref_p[b][addr], 1, 8, 0));
  endtask

  task automatic rd_done();
    i_rd_done = 1'b1;
    if (mfull[mrb]) begin
      mfull[mrb] = 0;
      mrb = !mrb;
    end
    step();
    i_rd_done = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_rd_done = 1'b0;
    step();
    areset = 1'b0;
    model_reset();
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int q[$];
    int n, hs, ha, hp;
    n_chk = 0; n_bad = 0;
    i_sys = '0; i_par = '0; i_apr = '0; i_addr = '0; i_rd_addr = '0;
    i_valid = 1'b0; i_last = 1'b0; i_rd_done = 1'b0;
    areset = 1'b1;
    step();
    do_reset();
    chk_status("reset");
    chk("reset:m0", o_metric0, 0);
    chk("reset:m1", o_metric1, 0);
    chk("reset:s_m0", s_metric0, 0);
    chk("reset:s_m1", s_metric1, 0);

    // release request with nothing to release
    rd_done();
    chk_status("idle_done");

    // single-beat frame
    send_beat(100, 20, 40, 5, 1);
    step();
    chk_status("one_beat");
    chk("one_beat:len1", o_frame_len, 1);
    rd_check("one_beat", 5);
    chk("one_beat:m0_80", o_metric0, 80);
    chk("one_beat:m1_40", o_metric1, 40);
    rd_done();

    // saturation extremes, lands in bank 1
    send_beat(32767, 32767, 32767, 0, 0);
    send_beat(-32768, -32768, -32768, 1, 1);
    step();
    chk_status("sat");
    rd_check("sat_hi", 0);
    chk("sat_hi:s_m0_127", s_metric0, 127);
    rd_check("sat_lo", 1);
    chk("sat_lo:s_m0_-127", s_metric0, -127);
    chk("sat_lo:s_m1_-127", s_metric1, -127);
    chk("sat_lo:m0_-32767", o_metric0, -32767);
    rd_done();

    // full-length frame A (m0 = addr) into bank 0
    for (int a = 0; a < BS; a++) begin
      int d;
      d = int'($urandom_range(0, 1000)) - 500;
      send_beat(a - d, 0, a + d, a, a == BS - 1);
    end
    step();
    chk_status("frameA");

    // frame B (m0 = addr+1) written while A is read
    fork
      begin
        for (int a = 0; a < BS; a++) begin
          int d;
          d = int'($urandom_range(0, 1000)) - 500;
          send_beat(a + 1 - d, 0, a + 1 + d, a, a == BS - 1);
        end
      end
      begin
        rd_check("A_first", 0);
        chk("A_first:m0_0", o_metric0, 0);
        rd_check("A_last", BS - 1);
        chk("A_last:m0_3071", o_metric0, 3071);
        for (int k = 0; k < 30; k++) rd_check("A_rand", int'($urandom_range(0, BS - 1)));
      end
    join
    chk("both_full:ready0", o_ready, 0);
    chk("both_full:lenA", o_frame_len, 3072);
    chk_status("both_full");

    // held beat stalls until the read bank is released
    hs = rnd16(); ha = rnd16(); hp = rnd16();
    i_sys = 16'(hs); i_apr = 16'(ha); i_par = 16'(hp);
    i_addr = AW'(7); i_last = 1'b0; i_valid = 1'b1;
    step();
    chk("held:stall1", o_ready, 0);
    step();
    chk("held:stall2", o_ready, 0);
    rd_done();
    chk("held:ready_after_done", o_ready, 1);
    chk("held:rbank1", o_rd_bank, 1);
    step();
    model_accept(hs, ha, hp, 7, 0);
    i_valid = 1'b0;
    rd_check("B_first", 0);
    chk("B_first:m0_1", o_metric0, 1);
    chk_status("held");

    // out-of-range address completes frame C
    send_beat(rnd16(), rnd16(), rnd16(), BS, 1);
    step();
    chk("oor:err", o_err_addr, 1);
    chk_status("oor");
    rd_done();
    chk("oor:lenC", o_frame_len, 2);
    rd_check("C_held", 7);
    chk_status("frameC");
    rd_done();

    // random short frames
    for (int f = 0; f < 6; f++) begin
      q.delete();
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) begin
        int a;
        a = int'($urandom_range(0, BS - 1));
        q.push_back(a);
        send_beat(rnd16(), rnd16(), rnd16(), a, i == n - 1);
      end
      step();
      chk_status("rand_frame");
      foreach (q[i]) rd_check("rand_rd", q[i]);
      rd_done();
    end

    // reset in the middle of a frame
    for (int a = 0; a < 1000; a++) send_beat(rnd16(), rnd16(), rnd16(), a, 0);
    do_reset();
    chk("mid_rst:ready", o_ready, 1);
    chk("mid_rst:frdy", o_frame_ready, 0);
    chk("mid_rst:len", o_frame_len, 0);
    chk("mid_rst:err", o_err_addr, 0);
    for (int a = 0; a < 4; a++) send_beat(rnd16(), rnd16(), rnd16(), a, a == 3);
    step();
    chk_status("post_rst");
    chk("post_rst:rbank0", o_rd_bank, 0);
    for (int a = 0; a < 4; a++) rd_check("post_rst_rd", a);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_metric_pingpong.md
Name: branch_metric_pingpong

Overview:
- Parametrised successor to the single-metric branch store in the SISO decoder.
- Per trellis step, computes both independent branch metrics from systematic, parity and a-priori (extrinsic) LLRs, with configurable scaling and saturation.
- Writes the metrics into a double-buffered (ping-pong) RAM, so frame N+1 can be written while the alpha/beta recursions read frame N.
- Adds frame handshake, backpressure, frame-length capture and address-error flagging.

Parameters:
- DWIDTH, 16: width of signed input LLRs.
- MWIDTH, 16: width of signed stored metric, MWIDTH <= DWIDTH+2.
- BRANCH_SIZE, 3072: maximum frame length; entries per bank.
- SHIFT, 1: arithmetic right shift applied before saturation (1 implements the 1/2 factor).
- AW, $clog2(BRANCH_SIZE): address width.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- i_sys  in  DWIDTH  signed systematic LLR.
- i_par  in  DWIDTH  signed parity LLR.
- i_apr  in  DWIDTH  signed a-priori LLR.
- i_addr  in  AW  trellis step index of input beat.
- i_valid  in  1  input beat valid.
- i_last  in  1  beat is final step of frame.
- o_ready  out  1  write bank free; beat accepted when i_valid && o_ready.
- o_frame_ready  out  1  read bank holds a complete frame.
- o_rd_bank  out  1  index of bank currently presented for reading.
- o_frame_len  out  AW+1  accepted beat count of read bank's frame.
- i_rd_addr  in  AW  read address into read bank.
- i_rd_done  in  1  pulse: reader finished with read bank.
- o_metric0  out  MWIDTH  signed metric for (u=+1,p=+1) at i_rd_addr; (-1,-1) is its negation.
- o_metric1  out  MWIDTH  signed metric for (u=+1,p=-1); (-1,+1) is its negation.
- o_err_addr  out  1  sticky: an accepted beat had i_addr >= BRANCH_SIZE.

Behaviour:
- Arithmetic: s = i_sys + i_apr, sign-extended to DWIDTH+2.
  - m0 = (s + i_par) >>> SHIFT; m1 = (s - i_par) >>> SHIFT.
  - Each result saturates symmetrically to [-(2^(MWIDTH-1)-1), 2^(MWIDTH-1)-1]; the most-negative code is never produced.
- Bank state: two banks, each FREE or FULL. Write pointer wb, read pointer rb.
  - o_ready = (bank[wb]==FREE).
  - o_frame_ready = (bank[rb]==FULL).
  - o_rd_bank = rb.
- Write pipeline: accepted beat at cycle t registers m0, m1, addr, bank tag=wb and last in stage 1. The RAM write occurs at t+1 into the tagged bank; data is readable from t+2.
- Frame length: per-bank counter increments on every accepted beat and clears at the first beat of a new frame into that bank.
- Frame completion: beat accepted with i_last sets bank[wb]=FULL and toggles wb, both effective at t+1. A beat on the very next cycle therefore targets the other bank, or is stalled if that bank is FULL.
- Release: i_rd_done while o_frame_ready sets bank[rb]=FREE and toggles rb next cycle. i_rd_done while !o_frame_ready is ignored.
- Read: registered, 1-cycle latency. o_metric0/1 at cycle t+1 reflect i_rd_addr at cycle t in bank rb. If rb toggles, the new bank applies from the following address sample.
- Simultaneous events:
  - Last acceptance and rd_done on different banks in the same cycle: both take effect.
  - Completion of the bank that rd_done would free cannot coincide, because a FULL bank is never written.
- Out-of-range address: beat is accepted, RAM write is suppressed, the counter still increments, and o_err_addr sets and holds until reset.
- Reset (mid-operation included):
  - Both banks FREE, wb=rb=0, counters 0, pipeline valid cleared; any partial or held frame is discarded.
  - Outputs: o_ready=1, o_frame_ready=0, o_rd_bank=0, o_frame_len=0, o_metric0/1=0, o_err_addr=0.
  - RAM contents are not reset.
- i_valid without o_ready: beat is not accepted and the source must hold it.

Test Plan:
- DWIDTH=16,SHIFT=1: sys=100, apr=20, par=40 at addr 5 with last; read addr 5 after o_frame_ready -> o_metric0=80, o_metric1=40, o_frame_len=1.
- MWIDTH=8,SHIFT=0: sys=32767, apr=32767, par=32767 -> m0=127. sys=-32768, apr=-32768, par=-32768 -> m0=-127, m1=-127 (never -128).
- Write 3072-beat frame A (m0=addr), then frame B (m0=addr+1) while reading A. Check A at addr 0=0 and 3071=3071. rd_done flips o_rd_bank to 1; B reads addr 0=1.
- Fill both banks without rd_done -> o_ready=0 one cycle after B's last; held beat is accepted the cycle after the rd_done pulse.
- rd_done with o_frame_ready=0 -> no state change. Beat with addr=3072 -> o_err_addr=1, no RAM write, len counts it.
- areset mid-frame (1000 of 3072 beats written) -> next cycle o_ready=1, o_frame_ready=0, o_frame_len=0; new 4-beat frame reads back correctly from bank 0.
